dds_pulse_scheduler: RTL and testbench
======================================

Name: dds_pulse_scheduler

Overview:
Frame-level sequencer for the AD9910 pulsed-sweep path, clocked on the 500 MHz DDS control clock.
- Per frame it drives drctl (ramp direction/arm), osk (RF gate) and drhold, and counts frames.
- It monitors drover to flag sweeps that did not complete.
- Configuration arrives through a valid/ready shadow register and takes effect only on frame boundaries, so the waveform never glitches mid-pulse.

Parameters:
PERIOD_W, 24, width of frame period in sys_clk cycles
WIDTH_W, 24, width of pulse-width field
COUNT_W, 16, width of frame-count field
LEAD, 2, cycles drctl leads osk at frame start (>=1)
MIN_OFF, 4, minimum cycles with osk=0 in each frame
HOLD_IN_OFF, 0, 1 = assert drhold during OFF state

Ports:
sys_clk  in  1  control clock (500 MHz)
sys_rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  new config offered
cfg_ready  out  1  shadow slot free
cfg_period  in  PERIOD_W  frame length in cycles
cfg_width  in  WIDTH_W  osk-high cycles per frame
cfg_count  in  COUNT_W  frames per burst, 0 = continuous
start  in  1  one-cycle burst start
stop  in  1  one-cycle graceful stop request
drover  in  1  DDS ramp-over flag, asynchronous
drctl  out  1  DDS ramp control
osk  out  1  DDS output shift keying
drhold  out  1  DDS ramp hold
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on burst completion or stop
cfg_err  out  1  one-cycle pulse when a rejected config is applied
drover_miss  out  1  sticky: some frame ended ON without drover; cleared on start
frame_idx  out  COUNT_W  index of current frame, 0-based

Behaviour:
- Reset (asynchronous): state IDLE. Outputs osk, drctl, drhold, busy, done, cfg_err, drover_miss and frame_idx all 0. cfg_ready=1. Active config zeroed (invalid). Shadow is empty.
- drover passes through a 2-flop synchroniser before use (2-cycle latency).
- Validity rule: width>=1 AND period >= LEAD+width+MIN_OFF. Compare in PERIOD_W+1 bits so there is no overflow.
- Config handshake:
  - Transfer occurs on cfg_valid&cfg_ready.
  - In IDLE, the accepted config applies to the active regs next cycle; cfg_ready stays 1.
  - While busy, the accepted config goes to the shadow; cfg_ready=0 until the shadow is consumed at the next frame boundary.
  - An invalid config at apply time gives a cfg_err pulse; the active config is retained and the shadow is freed.
- States:
  - IDLE: all DDS outputs low.
    - start with valid active config → LEAD; frame_idx=0; per-frame counter fc=0; drover_miss cleared.
    - start with invalid active config → cfg_err pulse, stay IDLE.
    - start and stop in the same cycle → stop wins, stay IDLE.
  - LEAD: drctl=1, osk=0 for frame cycles 0..LEAD-1.
  - ON: drctl=1, osk=1 for frame cycles LEAD..LEAD+width-1.
    - Record drover_seen if sync'd drover=1 in any ON cycle.
    - On leaving ON, set drover_miss if drover_seen=0.
  - OFF: drctl=0, osk=0, drhold=HOLD_IN_OFF, for cycles LEAD+width..period-1.
- Frame boundary (fc==period-1 in OFF): fc←0, drover_seen←0, and the first matching rule applies:
  - cfg_count!=0 and frame_idx+1==active count → IDLE, done pulse.
  - stop_pending → IDLE, done pulse.
  - Otherwise apply the shadow if present, frame_idx+1, → LEAD.
- frame_idx wraps at 2^COUNT_W in continuous mode.
- Frame period is exactly period cycles and back-to-back frames have no idle gap.
- stop while busy latches stop_pending; the current frame always completes. stop in IDLE is ignored.
- start while busy is ignored.
- Outputs are registered; the first DDS edge appears the cycle after start.

Decomposition:
- Shared package/include dds_sched_pkg holds:
  - state encoding (IDLE, LEAD, ON, OFF)
  - default widths
  - validity-check function
- One sub-module: dds_sync2 (2-flop synchroniser, async active-low reset), reused for drover.

Test Plan:
- LEAD=2, MIN_OFF=4, config period=20, width=5, count=3; start at T → drctl high T+1..T+7, osk high T+3..T+7; frames repeat at T+21 and T+41; done at T+61; busy low at T+61.
- drover held 0 during the above → drover_miss=1 after the first ON; drover pulsed inside each ON → drover_miss stays 0; a later start clears it.
- Mid-burst cfg (period=30, width=8) during frame 0 → cfg_ready=0 until the frame-1 boundary; frame 1 uses the new timing; frame 0 is unchanged.
- Invalid config period=10, width=5 in IDLE → cfg_err pulse; the following start runs the previous valid config; from reset, start → cfg_err with no outputs.
- count=0, stop asserted mid-ON of frame 4 → frame 4 completes fully, done pulse at its boundary, outputs stay low afterwards; start+stop in the same IDLE cycle → no activity.
- sys_rst asserted during ON → osk/drctl/busy go low asynchronously; after release, IDLE with cfg_ready=1.

Source files
------------

// File: rtl/dds_sched_pkg.sv
// dds_sched_pkg: shared state encoding, default field widths and the config validity check
package dds_sched_pkg;

    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_WIDTH_W  = 24;
    localparam int DEF_COUNT_W  = 16;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_ON, S_OFF} state_t;

    // A config is usable when the pulse is non-empty and the frame holds lead + pulse + minimum off time.
    // Sums are done 34 bits wide so no field combination can overflow.
    function automatic logic cfg_ok(input logic [31:0] period, input logic [31:0] width,
                                    input logic [31:0] lead, input logic [31:0] min_off);
        return (width != 32'd0) &&
               ({2'b00, period} >= {2'b00, lead} + {2'b00, width} + {2'b00, min_off});
    endfunction

endpackage

// File: rtl/dds_sync2.sv
// dds_sync2: two-flop synchroniser for an asynchronous single-bit input
//   sys_clk : destination clock
//   sys_rst : asynchronous active-low reset, output clears to 0
//   d       : asynchronous input
//   q       : synchronised copy of d, two cycles late
module dds_sync2 (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) {q, meta} <= 2'b00;
        else          {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/dds_pulse_scheduler.sv
// dds_pulse_scheduler: frame sequencer driving AD9910 drctl/osk/drhold with glitch-free config updates
//   sys_clk, sys_rst           : control clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        : config handshake; cfg_period/cfg_width/cfg_count carry the config
//   start, stop                : one-cycle burst start and graceful stop request
//   drover                     : asynchronous DDS ramp-over flag
//   drctl, osk, drhold         : registered DDS controls
//   busy, done, cfg_err        : status; done and cfg_err are one-cycle pulses
//   drover_miss                : sticky, a pulse ended without drover; cleared by a valid start
//   frame_idx                  : 0-based index of the current frame
module dds_pulse_scheduler
    import dds_sched_pkg::*;
#(
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int LEAD        = 2,
    parameter int MIN_OFF     = 4,
    parameter int HOLD_IN_OFF = 0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [WIDTH_W-1:0]  cfg_width,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic                start,
    input  logic                stop,
    input  logic                drover,
    output logic                drctl,
    output logic                osk,
    output logic                drhold,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                drover_miss,
    output logic [COUNT_W-1:0]  frame_idx
);
    state_t state, state_nx;
    logic [PERIOD_W-1:0] fc, fc_nx, act_period, act_period_nx, shd_period;
    logic [WIDTH_W-1:0]  act_width, act_width_nx, shd_width;
    logic [COUNT_W-1:0]  act_count, act_count_nx, shd_count, frame_idx_nx;
    logic shd_full, shd_full_nx, stop_pend, stop_pend_nx, seen, seen_nx;
    logic miss_nx, done_nx, err_nx;
    logic drover_s, acc, in_ok, shd_ok, act_ok, last_lead, last_on, boundary, shd_apply;

    dds_sync2 u_sync (.sys_clk(sys_clk), .sys_rst(sys_rst), .d(drover), .q(drover_s));

    assign cfg_ready = !shd_full;
    assign acc       = cfg_valid && !shd_full;
    assign in_ok     = cfg_ok(32'(cfg_period), 32'(cfg_width), LEAD, MIN_OFF);
    assign shd_ok    = cfg_ok(32'(shd_period), 32'(shd_width), LEAD, MIN_OFF);
    assign act_ok    = cfg_ok(32'(act_period), 32'(act_width), LEAD, MIN_OFF);
    assign last_lead = 32'(fc) == LEAD - 1;
    assign last_on   = 32'(fc) == LEAD + 32'(act_width) - 1;
    assign boundary  = state == S_OFF && fc == act_period - 1'b1;
    // The shadow drains at every frame boundary, and in IDLE if a config slipped in on the final boundary.
    assign shd_apply = shd_full && (boundary || state == S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        fc_nx         = fc + 1'b1;
        frame_idx_nx  = frame_idx;
        seen_nx       = seen;
        miss_nx       = drover_miss;
        stop_pend_nx  = stop_pend || (stop && state != S_IDLE);
        shd_full_nx   = shd_full || (acc && state != S_IDLE);
        done_nx       = 1'b0;
        err_nx        = 1'b0;
        act_period_nx = act_period;
        act_width_nx  = act_width;
        act_count_nx  = act_count;
        if (shd_apply) begin
            shd_full_nx = 1'b0;
            if (shd_ok) {act_period_nx, act_width_nx, act_count_nx} = {shd_period, shd_width, shd_count};
            else        err_nx = 1'b1;
        end else if (acc && state == S_IDLE) begin
            if (in_ok) {act_period_nx, act_width_nx, act_count_nx} = {cfg_period, cfg_width, cfg_count};
            else       err_nx = 1'b1;
        end
        case (state)
            S_IDLE: begin
                fc_nx = '0;
                if (start && !stop) begin
                    if (act_ok) begin
                        state_nx     = S_LEAD;
                        frame_idx_nx = '0;
                        seen_nx      = 1'b0;
                        miss_nx      = 1'b0;
                        stop_pend_nx = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_LEAD: if (last_lead) state_nx = S_ON;
            S_ON: begin
                seen_nx = seen || drover_s;
                if (last_on) begin
                    state_nx = S_OFF;
                    miss_nx  = drover_miss || !seen_nx;
                end
            end
            S_OFF: if (boundary) begin
                fc_nx   = '0;
                seen_nx = 1'b0;
                // A stop raised on the last cycle still belongs to this frame.
                if ((act_count != '0 && frame_idx + 1'b1 == act_count) || stop_pend || stop) begin
                    state_nx     = S_IDLE;
                    done_nx      = 1'b1;
                    stop_pend_nx = 1'b0;
                end else begin
                    state_nx     = S_LEAD;
                    frame_idx_nx = frame_idx + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fc          <= '0;
            frame_idx   <= '0;
            act_period  <= '0;
            act_width   <= '0;
            act_count   <= '0;
            shd_period  <= '0;
            shd_width   <= '0;
            shd_count   <= '0;
            shd_full    <= 1'b0;
            stop_pend   <= 1'b0;
            seen        <= 1'b0;
            drover_miss <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            drctl       <= 1'b0;
            osk         <= 1'b0;
            drhold      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fc          <= fc_nx;
            frame_idx   <= frame_idx_nx;
            act_period  <= act_period_nx;
            act_width   <= act_width_nx;
            act_count   <= act_count_nx;
            shd_full    <= shd_full_nx;
            stop_pend   <= stop_pend_nx;
            seen        <= seen_nx;
            drover_miss <= miss_nx;
            done        <= done_nx;
            cfg_err     <= err_nx;
            if (acc && state != S_IDLE) {shd_period, shd_width, shd_count} <= {cfg_period, cfg_width, cfg_count};
            // Outputs decode the next state so every DDS line comes straight from a flop.
            drctl       <= state_nx == S_LEAD || state_nx == S_ON;
            osk         <= state_nx == S_ON;
            drhold      <= HOLD_IN_OFF != 0 && state_nx == S_OFF;
            busy        <= state_nx != S_IDLE;
        end
    end
endmodule

// File: tb/tb_dds_pulse_scheduler.sv
// tb_dds_pulse_scheduler: randomized and directed bench with a frame-arithmetic reference model
module tb_dds_pulse_scheduler;
    localparam int LEAD    = 2;
    localparam int MIN_OFF = 4;

    logic sys_clk = 1'b0, sys_rst = 1'b0;
    logic cfg_valid = 1'b0, cfg_ready, start = 1'b0, stop = 1'b0, drover = 1'b0;
    logic [23:0] cfg_period = '0, cfg_width = '0;
    logic [3:0]  cfg_count = '0, frame_idx;
    logic drctl, osk, drhold, busy, done, cfg_err, drover_miss;
    int checks = 0, errors = 0, mode = 0;

    dds_pulse_scheduler #(.PERIOD_W(24), .WIDTH_W(24), .COUNT_W(4), .LEAD(LEAD),
                          .MIN_OFF(MIN_OFF), .HOLD_IN_OFF(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_count(cfg_count),
        .start(start), .stop(stop), .drover(drover), .drctl(drctl), .osk(osk),
        .drhold(drhold), .busy(busy), .done(done), .cfg_err(cfg_err),
        .drover_miss(drover_miss), .frame_idx(frame_idx));

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        #1;
        drover = mode == 1 ? 1'b1 : mode == 2 ? ($urandom % 4 == 0) : 1'b0;
    end

    // Reference model: a burst is a sequence of frames; k is the cycle number inside the current frame.
    int m_per = 0, m_wid = 0, m_cnt = 0, s_per = 0, s_wid = 0, s_cnt = 0, m_k = 0, m_idx = 0;
    bit m_busy = 0, s_full = 0, m_stop = 0, m_seen = 0, m_miss = 0, m_done = 0, m_err = 0;
    bit h1 = 0, h2 = 0, m_ds, m_acc, m_end, m_was;

    function automatic bit ok(int p, int w);
        return w >= 1 && p >= LEAD + w + MIN_OFF;
    endfunction

    task automatic m_apply(int p, int w, int c);
        if (ok(p, w)) begin
            m_per = p; m_wid = w; m_cnt = c;
        end else m_err = 1;
    endtask

    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            m_per = 0; m_wid = 0; m_cnt = 0; s_full = 0; m_busy = 0; m_stop = 0; m_seen = 0;
            m_miss = 0; m_done = 0; m_err = 0; m_idx = 0; m_k = 0; h1 = 0; h2 = 0;
        end else begin
            m_ds = h2; h2 = h1; h1 = drover;
            m_acc = cfg_valid && !s_full;
            m_done = 0; m_err = 0;
            if (!m_busy) begin
                if (start && !stop) begin
                    if (ok(m_per, m_wid)) begin
                        m_busy = 1; m_k = 0; m_idx = 0; m_miss = 0; m_seen = 0; m_stop = 0;
                    end else m_err = 1;
                end
                if (s_full) begin
                    m_apply(s_per, s_wid, s_cnt); s_full = 0;
                end else if (m_acc) m_apply(int'(cfg_period), int'(cfg_width), int'(cfg_count));
            end else begin
                m_was = s_full;
                if (m_acc) begin
                    s_full = 1; s_per = int'(cfg_period); s_wid = int'(cfg_width); s_cnt = int'(cfg_count);
                end
                if (stop) m_stop = 1;
                if (m_k >= LEAD && m_k < LEAD + m_wid) begin
                    m_seen |= m_ds;
                    if (m_k == LEAD + m_wid - 1 && !m_seen) m_miss = 1;
                end
                if (m_k == m_per - 1) begin
                    m_seen = 0;
                    m_end = (m_cnt != 0 && (m_idx + 1) % 16 == m_cnt) || m_stop;
                    if (m_was) begin
                        m_apply(s_per, s_wid, s_cnt); s_full = 0;
                    end
                    if (m_end) begin
                        m_busy = 0; m_done = 1; m_stop = 0;
                    end else begin
                        m_idx = (m_idx + 1) % 16; m_k = 0;
                    end
                end else m_k++;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            cmp("busy", 32'(busy), 32'(m_busy));
            cmp("drctl", 32'(drctl), 32'(m_busy && m_k < LEAD + m_wid));
            cmp("osk", 32'(osk), 32'(m_busy && m_k >= LEAD && m_k < LEAD + m_wid));
            cmp("drhold", 32'(drhold), 32'(m_busy && m_k >= LEAD + m_wid));
            cmp("cfg_ready", 32'(cfg_ready), 32'(!s_full));
            cmp("done", 32'(done), 32'(m_done));
            cmp("cfg_err", 32'(cfg_err), 32'(m_err));
            cmp("drover_miss", 32'(drover_miss), 32'(m_miss));
            cmp("frame_idx", 32'(frame_idx), 32'(m_idx));
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic offer(int p, int w, int c);
        cfg_period = 24'(p); cfg_width = 24'(w); cfg_count = 4'(c); cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    initial begin
        step(3);
        sys_rst = 1'b1;
        step(1);
        cmp("rst_ready", 32'(cfg_ready), 1); cmp("rst_busy", 32'(busy), 0);
        cmp("rst_drctl", 32'(drctl), 0); cmp("rst_idx", 32'(frame_idx), 0);
        pulse_start();
        cmp("zero_cfg_err", 32'(cfg_err), 1); cmp("zero_cfg_busy", 32'(busy), 0);
        cmp("zero_cfg_osk", 32'(osk), 0);
        offer(20, 5, 3);
        cmp("good_cfg_err", 32'(cfg_err), 0);
        step(2);
        pulse_start();
        cmp("t1_drctl", 32'(drctl), 1); cmp("t1_osk", 32'(osk), 0);
        step(2);
        cmp("t3_osk", 32'(osk), 1);
        step(4);
        cmp("t7_osk", 32'(osk), 1); cmp("t7_drctl", 32'(drctl), 1);
        step(1);
        cmp("t8_drctl", 32'(drctl), 0); cmp("t8_osk", 32'(osk), 0);
        cmp("t8_hold", 32'(drhold), 1); cmp("t8_miss", 32'(drover_miss), 1);
        step(13);
        cmp("t21_drctl", 32'(drctl), 1); cmp("t21_idx", 32'(frame_idx), 1);
        step(20);
        cmp("t41_drctl", 32'(drctl), 1); cmp("t41_idx", 32'(frame_idx), 2);
        step(19);
        cmp("t60_busy", 32'(busy), 1); cmp("t60_done", 32'(done), 0);
        step(1);
        cmp("t61_done", 32'(done), 1); cmp("t61_busy", 32'(busy), 0);
        mode = 1;
        pulse_start();
        cmp("start_clears_miss", 32'(drover_miss), 0);
        step(60);
        cmp("pulsed_done", 32'(done), 1); cmp("pulsed_miss", 32'(drover_miss), 0);
        offer(10, 5, 2);
        cmp("invalid_err", 32'(cfg_err), 1);
        pulse_start();
        step(7);
        cmp("old_cfg_t8_drctl", 32'(drctl), 0);
        step(53);
        cmp("old_cfg_t61_done", 32'(done), 1);
        pulse_start();
        step(4);
        offer(30, 8, 3);
        cmp("shadow_ready_low", 32'(cfg_ready), 0);
        step(14);
        cmp("t20_ready_low", 32'(cfg_ready), 0);
        step(1);
        cmp("t21_ready", 32'(cfg_ready), 1); cmp("t21_new_drctl", 32'(drctl), 1);
        step(9);
        cmp("t30_new_osk", 32'(osk), 1);
        step(1);
        cmp("t31_new_drctl", 32'(drctl), 0);
        step(20);
        cmp("t51_drctl", 32'(drctl), 1); cmp("t51_idx", 32'(frame_idx), 2);
        step(30);
        cmp("t81_done", 32'(done), 1);
        offer(20, 5, 0);
        pulse_start();
        step(84);
        stop = 1'b1; step(1); stop = 1'b0;
        step(14);
        cmp("stop_t100_busy", 32'(busy), 1); cmp("stop_t100_idx", 32'(frame_idx), 4);
        step(1);
        cmp("stop_t101_done", 32'(done), 1); cmp("stop_t101_busy", 32'(busy), 0);
        step(5);
        cmp("stop_after_drctl", 32'(drctl), 0);
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        cmp("start_stop_busy", 32'(busy), 0); cmp("start_stop_drctl", 32'(drctl), 0);
        offer(7, 1, 0);
        pulse_start();
        step(112);
        cmp("wrap_idx", 32'(frame_idx), 0); cmp("wrap_drctl", 32'(drctl), 1);
        step(7);
        cmp("wrap_idx1", 32'(frame_idx), 1);
        stop = 1'b1; step(1); stop = 1'b0;
        step(6);
        cmp("wrap_done", 32'(done), 1);
        mode = 2;
        for (int i = 0; i < 3000; i++) begin
            cfg_valid  = ($urandom % 16 == 0);
            cfg_period = 24'($urandom_range(8, 40));
            cfg_width  = 24'($urandom_range(0, 12));
            cfg_count  = 4'($urandom_range(0, 4));
            start      = ($urandom % 24 == 0);
            stop       = ($urandom % 80 == 0);
            step(1);
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(50);
        cmp("rand_drain_busy", 32'(busy), 0);
        mode = 0;
        offer(20, 5, 3);
        pulse_start();
        step(3);
        sys_rst = 1'b0;
        #1;
        cmp("async_osk", 32'(osk), 0); cmp("async_drctl", 32'(drctl), 0);
        cmp("async_busy", 32'(busy), 0); cmp("async_ready", 32'(cfg_ready), 1);
        #5;
        sys_rst = 1'b1;
        step(1);
        cmp("post_rst_busy", 32'(busy), 0); cmp("post_rst_ready", 32'(cfg_ready), 1);
        pulse_start();
        cmp("post_rst_err", 32'(cfg_err), 1); cmp("post_rst_idle", 32'(busy), 0);
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
